// File: rtl/arcade_input_pkg.sv
// Shared constants for the arcade input controller: button indices and the
// default PS/2 keyboard-to-button map.
package arcade_input_pkg;

    localparam int RIGHT  = 0;
    localparam int LEFT   = 1;
    localparam int DOWN   = 2;
    localparam int UP     = 3;
    localparam int FIRE1  = 4;
    localparam int FIRE2  = 5;
    localparam int START1 = 6;
    localparam int START2 = 7;
    localparam int COIN   = 8;
    localparam int PAUSE  = 9;
    localparam int TEST   = 10;

    typedef struct packed {
        logic       valid;
        logic       ext;
        logic [7:0] code;
        logic [3:0] index;
    } keymap_t;

    localparam int KEYMAP_N = 12;

    // Ctrl (14) and Alt (11) share fire1; each key event writes the shared bit.
    localparam keymap_t KEYMAP [KEYMAP_N] = '{
        '{1'b1, 1'b0, 8'h75, 4'(UP)},
        '{1'b1, 1'b0, 8'h72, 4'(DOWN)},
        '{1'b1, 1'b0, 8'h6B, 4'(LEFT)},
        '{1'b1, 1'b0, 8'h74, 4'(RIGHT)},
        '{1'b1, 1'b0, 8'h14, 4'(FIRE1)},
        '{1'b1, 1'b0, 8'h11, 4'(FIRE1)},
        '{1'b1, 1'b0, 8'h29, 4'(FIRE2)},
        '{1'b1, 1'b0, 8'h05, 4'(START1)},
        '{1'b1, 1'b0, 8'h06, 4'(START2)},
        '{1'b1, 1'b0, 8'h04, 4'(COIN)},
        '{1'b1, 1'b0, 8'h0C, 4'(PAUSE)},
        '{1'b1, 1'b0, 8'h03, 4'(TEST)}
    };

endpackage

// File: rtl/arcade_input_ctrl_if.sv
// Bus between the host core and the input controller: keyboard/joystick in,
// conditioned active-low buttons and status out.
interface arcade_input_ctrl_if #(
    parameter int NPLAYERS = 2,
    parameter int NBTN     = 10
);
    logic [10:0]              ps2_key;
    logic [16*NPLAYERS-1:0]   joy;
    logic                     af_en;
    logic [NBTN*NPLAYERS-1:0] btn_n;
    logic                     pause;
    logic                     test;

    modport master (output ps2_key, joy, af_en, input btn_n, pause, test);
    modport slave  (input ps2_key, joy, af_en, output btn_n, pause, test);
endinterface

// File: rtl/arcade_pulse_stretch.sv
// Rising-edge detector that emits a registered pulse exactly LEN cycles long.
// Edges arriving while the pulse is active are dropped.
module arcade_pulse_stretch #(
    parameter int LEN = 16
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic din,
    output logic pulse
);
    localparam int CW = $clog2(LEN + 1);

    logic [CW-1:0] cnt;
    logic          din_q;

    // Edge detect and countdown; din_q resets high so a held input is not an edge.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt   <= '0;
            pulse <= 1'b0;
            din_q <= 1'b1;
        end else begin
            din_q <= din;
            if (din && !din_q && !pulse) begin
                cnt   <= CW'(LEN - 1);
                pulse <= 1'b1;
            end else if (cnt != '0) begin
                cnt   <= cnt - 1'b1;
                pulse <= 1'b1;
            end else begin
                pulse <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/arcade_input_ctrl.sv
// Arcade input conditioning: PS/2 keymap + joystick merge, pause latch,
// coin pulse stretching and autofire. Two-stage pipe: input regs, output regs.
module arcade_input_ctrl
    import arcade_input_pkg::*;
#(
    parameter int NPLAYERS  = 2,
    parameter int NBTN      = 10,
    parameter int MERGE     = 1,
    parameter int COIN_IDX  = 8,
    parameter int PAUSE_IDX = 9,
    parameter int FIRE_IDX  = 4,
    parameter int COIN_LEN  = 16,
    parameter int AF_HALF   = 4096
) (
    input logic clk_sys,
    input logic reset,
    arcade_input_ctrl_if.slave bus
);
    localparam int AW = $clog2(AF_HALF + 1);

    logic                           ps2_tog_q;
    logic [15:0]                    kbd, kbd_nx;
    logic [NPLAYERS-1:0][NBTN-1:0]  joy_q;
    logic [NBTN-1:0]                joy_any;
    logic [NPLAYERS-1:0][NBTN-1:0]  raw, pass_q, btn;
    logic [NPLAYERS-1:0]            pause_raw, pause_prev, coin, fire;
    logic                           pause_q, test_q;
    logic                           unused_bits;

    assign unused_bits = ^{bus.joy, kbd};

    // Keymap lookup on a toggle change; unmatched codes leave state untouched.
    always_comb begin
        kbd_nx = kbd;
        if (bus.ps2_key[10] != ps2_tog_q) begin
            for (int k = 0; k < KEYMAP_N; k++) begin
                if (KEYMAP[k].valid && KEYMAP[k].ext == bus.ps2_key[8] &&
                    KEYMAP[k].code == bus.ps2_key[7:0])
                    kbd_nx[KEYMAP[k].index] = bus.ps2_key[9];
            end
        end
    end

    // Keyboard state register; toggle reg tracks ps2_key[10] in reset so no stale event.
    always_ff @(posedge clk_sys) begin
        ps2_tog_q <= bus.ps2_key[10];
        if (reset) kbd <= '0;
        else       kbd <= kbd_nx;
    end

    // Joystick input register, unreset so a button held through reset stays steady.
    always_ff @(posedge clk_sys) begin
        for (int p = 0; p < NPLAYERS; p++)
            joy_q[p] <= bus.joy[16*p +: NBTN];
    end

    // Raw buttons: keyboard and joysticks combined according to MERGE.
    always_comb begin
        joy_any = '0;
        raw     = '0;
        for (int p = 0; p < NPLAYERS; p++)
            joy_any = joy_any | joy_q[p];
        for (int p = 0; p < NPLAYERS; p++) begin
            if (MERGE != 0)  raw[p] = joy_any | kbd[NBTN-1:0];
            else if (p == 0) raw[p] = joy_q[p] | kbd[NBTN-1:0];
            else             raw[p] = joy_q[p];
            pause_raw[p] = raw[p][PAUSE_IDX];
        end
    end

    // Output-stage registers for pass-through buttons, pause latch and test key.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            pass_q     <= '0;
            pause_q    <= 1'b0;
            pause_prev <= '1;
            test_q     <= 1'b0;
        end else begin
            pass_q     <= raw;
            test_q     <= kbd[TEST];
            pause_prev <= pause_raw;
            if (|(pause_raw & ~pause_prev)) pause_q <= ~pause_q;
        end
    end

    for (genvar p = 0; p < NPLAYERS; p++) begin : g_pl
        logic          af_act, af_run, fire_q;
        logic [AW-1:0] af_cnt;

        arcade_pulse_stretch #(.LEN(COIN_LEN)) u_coin (
            .clk_sys (clk_sys),
            .reset   (reset),
            .din     (raw[p][COIN_IDX]),
            .pulse   (coin[p])
        );

        assign af_act  = bus.af_en & raw[p][FIRE_IDX];
        assign fire[p] = fire_q;

        // Autofire: on for AF_HALF, off for AF_HALF; restarts whenever autofire begins.
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                af_cnt <= '0;
                af_run <= 1'b0;
                fire_q <= 1'b0;
            end else begin
                af_run <= af_act;
                if (!af_act) begin
                    af_cnt <= '0;
                    fire_q <= raw[p][FIRE_IDX];
                end else if (!af_run || af_cnt == '0) begin
                    af_cnt <= AW'(AF_HALF - 1);
                    fire_q <= !af_run ? 1'b1 : ~fire_q;
                end else begin
                    af_cnt <= af_cnt - 1'b1;
                end
            end
        end
    end

    // Assemble the output word; pause is consumed by the latch and never shown.
    always_comb begin
        btn = pass_q;
        for (int p = 0; p < NPLAYERS; p++) begin
            btn[p][COIN_IDX]  = coin[p];
            btn[p][FIRE_IDX]  = fire[p];
            btn[p][PAUSE_IDX] = 1'b0;
        end
    end

    assign bus.btn_n = ~btn;
    assign bus.pause = pause_q;
    assign bus.test  = test_q;
endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl: a merged instance (fast autofire) and
// a non-merged instance share clock and reset.
module tb_arcade_input_ctrl;
    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    logic tog     = 1'b0;
    int   n_chk   = 0;
    int   n_fail  = 0;

    localparam logic [19:0] ALL1 = 20'hFFFFF;

    always #5 clk_sys = ~clk_sys;

    arcade_input_ctrl_if #(.NPLAYERS(2), .NBTN(10)) if0 ();
    arcade_input_ctrl_if #(.NPLAYERS(2), .NBTN(10)) if1 ();

    arcade_input_ctrl #(.NPLAYERS(2), .NBTN(10), .MERGE(1), .COIN_LEN(16), .AF_HALF(4)) dut0 (
        .clk_sys (clk_sys), .reset (reset), .bus (if0.slave));
    arcade_input_ctrl #(.NPLAYERS(2), .NBTN(10), .MERGE(0), .COIN_LEN(16), .AF_HALF(4096)) dut1 (
        .clk_sys (clk_sys), .reset (reset), .bus (if1.slave));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic key(input logic [7:0] code, input logic pr);
        tog = ~tog;
        if0.ps2_key = {tog, pr, 1'b0, code};
        if1.ps2_key = {tog, pr, 1'b0, code};
    endtask

    initial begin
        int lows, lows0, first, pulses;
        logic b, prevb;

        if0.ps2_key = '0; if1.ps2_key = '0;
        if0.joy = '0;     if1.joy = '0;
        if0.af_en = 1'b0; if1.af_en = 1'b0;
        step(3);
        chk("rst_btn", if0.btn_n, ALL1);
        chk("rst_pause", if0.pause, 0);
        chk("rst_test", if0.test, 0);
        reset = 1'b0;
        step(2);

        // keyboard up: 2-cycle latency each way
        key(8'h75, 1'b1);
        step(1); chk("up_lat1", if0.btn_n[3], 1);
        step(1); chk("up_press", if0.btn_n, 20'hFDFF7);
        chk("up_press_m0", if1.btn_n, 20'hFFFF7);
        key(8'h75, 1'b0);
        step(1); chk("up_rel_lat1", if0.btn_n[3], 0);
        step(1); chk("up_rel", if0.btn_n, ALL1);

        // test key
        key(8'h03, 1'b1);
        step(1); chk("test_lat1", if0.test, 0);
        step(1); chk("test_on", if0.test, 1);
        chk("test_btn", if0.btn_n, ALL1);
        key(8'h03, 1'b0);
        step(2); chk("test_off", if0.test, 0);

        // ctrl and alt share fire1, last event wins
        key(8'h14, 1'b1); step(2); chk("ctrl_fire", if0.btn_n[4], 0);
        key(8'h11, 1'b1); step(2); chk("alt_fire", if0.btn_n[4], 0);
        key(8'h14, 1'b0); step(2); chk("ctrl_rel_wins", if0.btn_n[4], 1);
        key(8'h11, 1'b0); step(2);

        key(8'h1C, 1'b1); step(2); chk("unmapped", if0.btn_n, ALL1);
        key(8'h1C, 1'b0); step(2);

        // coin on player 1 with a re-press inside the pulse
        lows = 0; lows0 = 0; first = 0; pulses = 0; prevb = 1'b1;
        if0.joy[24] = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            step(1);
            b = if0.btn_n[18];
            if (!if0.btn_n[8]) lows0++;
            if (!b) begin
                lows++;
                if (first == 0) first = c;
                if (prevb) pulses++;
            end
            prevb = b;
            if (c == 3)   if0.joy[24] = 1'b0;
            if (c == 5)   if0.joy[24] = 1'b1;
            if (c == 100) if0.joy[24] = 1'b0;
        end
        chk("coin_len", lows, 16);
        chk("coin_first", first, 2);
        chk("coin_once", pulses, 1);
        chk("coin_merge_p0", lows0, 16);

        // pause from both players at once toggles once
        if0.joy[9] = 1'b1; if0.joy[25] = 1'b1;
        step(1); chk("pause_lat1", if0.pause, 0);
        if0.joy[9] = 1'b0; if0.joy[25] = 1'b0;
        step(1); chk("pause_on", if0.pause, 1);
        chk("pause_btn_hidden", {if0.btn_n[19], if0.btn_n[9]}, 2'b11);
        step(3); chk("pause_once", if0.pause, 1);
        if0.joy[9] = 1'b1; step(2); if0.joy[9] = 1'b0;
        chk("pause_off", if0.pause, 0);
        step(2);
        if0.joy[25] = 1'b1; step(2); if0.joy[25] = 1'b0;
        chk("pause_on2", if0.pause, 1);
        reset = 1'b1; step(3); reset = 1'b0; step(1);
        chk("pause_rst", if0.pause, 0);

        // autofire, AF_HALF=4: low 4, high 4, starting low; release -> high
        if0.af_en = 1'b1;
        if0.joy[4] = 1'b1;
        for (int c = 1; c <= 23; c++) begin
            step(1);
            if (c < 2 || c >= 22) chk($sformatf("af_c%0d", c), if0.btn_n[4], 1);
            else chk($sformatf("af_c%0d", c), if0.btn_n[4], ((c - 2) / 4) % 2);
            if (c == 20) if0.joy[4] = 1'b0;
        end
        if0.af_en = 1'b0;
        step(2);

        // MERGE=0 routing
        if1.joy[16] = 1'b1; step(2);
        chk("m0_joy_p1", if1.btn_n, 20'hFFBFF);
        if1.joy[16] = 1'b0; step(2);
        key(8'h74, 1'b1); step(2);
        chk("m0_kbd_p0", if1.btn_n, 20'hFFFFE);
        chk("m1_kbd_all", if0.btn_n, 20'hFFBFE);
        key(8'h74, 1'b0); step(2);

        // coin held and ps2 toggle flipped during reset: nothing afterwards
        reset = 1'b1;
        if0.joy[8] = 1'b1;
        key(8'h75, 1'b1);
        step(3);
        reset = 1'b0;
        lows = 0;
        for (int c = 0; c < 30; c++) begin
            step(1);
            if (!if0.btn_n[8]) lows++;
        end
        chk("rst_coin_held", lows, 0);
        chk("rst_no_key", if0.btn_n, ALL1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/arcade_input_ctrl.md
ARCADE_INPUT_CTRL -- requirements
Module: arcade_input_ctrl

Interface
REQ-001 SHALL have parameter NPLAYERS, 2, number of player input channels (1..4).
REQ-002 SHALL have parameter NBTN, 10, buttons per player, taken from joystick bits [NBTN-1:0] (6..16).
REQ-003 SHALL have parameter MERGE, 1, 1 = all joysticks and keyboard ORed into every player; 0 = joystick p drives player p only, keyboard drives player 0 only.
REQ-004 SHALL have parameter COIN_IDX, 8, button index of the coin input.
REQ-005 SHALL have parameter PAUSE_IDX, 9, button index of the pause input.
REQ-006 SHALL have parameter FIRE_IDX, 4, button index subject to autofire.
REQ-007 SHALL have parameter COIN_LEN, 16, coin pulse length in clk_sys cycles (>=2).
REQ-008 SHALL have parameter AF_HALF, 4096, autofire half-period in clk_sys cycles (>=1).
REQ-009 clk_sys  in  1  system clock, all logic on rising edge.
REQ-010 reset  in  1  synchronous, active-high reset.
REQ-011 ps2_key  in  11  [10] event toggle, [9] pressed, [8] extended, [7:0] scan code.
REQ-012 joy  in  16*NPLAYERS  player p joystick in bits [16p+15:16p], active-high.
REQ-013 af_en  in  1  autofire enable, level.
REQ-014 btn_n  out  NBTN*NPLAYERS  conditioned buttons, active-low, player p in [NBTN*p+NBTN-1:NBTN*p].
REQ-015 pause  out  1  pause latch, active-high.
REQ-016 test  out  1  keyboard test key state, active-high.

Function
REQ-017 SHALL register keyboard state when ps2_key[10] differs from its value registered the previous cycle; {ps2_key[8],ps2_key[7:0]} looked up in KEYMAP, matching button bit set to ps2_key[9]; unmatched codes ignored.
REQ-018 Multiple KEYMAP entries mapping to one index (e.g. ctrl and alt to fire1) SHALL each set/clear the shared bit independently (last event wins).
REQ-019 Raw button r[p][i] SHALL be the OR of the keyboard bit (per MERGE) and the joystick bits (per MERGE); registered once (1 cycle).
REQ-020 pause SHALL toggle on a rising edge of raw pause from any player; simultaneous edges from several players SHALL toggle once.
REQ-021 Coin: rising edge of raw coin on player p SHALL assert coin for exactly COIN_LEN cycles; edges during an active pulse ignored; per-player independent counter.
REQ-022 Autofire: when af_en=1 and raw fire held, fire output SHALL be asserted for AF_HALF cycles, deasserted AF_HALF cycles, repeating; phase counter restarts at press so first AF_HALF cycles are asserted; release deasserts next cycle.
REQ-023 When af_en=0 fire SHALL follow raw fire; af_en change mid-hold takes effect next cycle, counter restarts.
REQ-024 All other buttons SHALL pass raw value; pause index output SHALL be forced inactive (consumed by the latch).
REQ-025 Total latency ps2/joy change to btn_n SHALL be 2 cycles (input register + output register).
REQ-026 test SHALL be the keyboard test-key bit, 2-cycle latency.

Reset
REQ-027 On reset: btn_n all ones, pause 0, test 0, keyboard state 0, coin counters 0, autofire counters 0, ps2 toggle register loaded with current ps2_key[10] (no spurious event).
REQ-028 Reset mid coin pulse or autofire SHALL terminate it; a button held through reset SHALL NOT generate coin/pause edge on release of reset.

Structure
REQ-029 Package arcade_input_pkg SHALL hold button index constants (RIGHT=0, LEFT=1, DOWN=2, UP=3, FIRE1=4, FIRE2=5, START1=6, START2=7, COIN=8, PAUSE=9, TEST=10), the KEYMAP entry type {valid, ext, code, index} and default KEYMAP: 75 up, 72 down, 6B left, 74 right, 14/11 fire1, 29 fire2, 05 start1, 06 start2, 04 coin, 0C pause, 03 test.
REQ-030 One sub-module arcade_pulse_stretch (edge detect + COIN_LEN counter) SHALL be instantiated per player.

Verification
REQ-031 ps2 event code 75 pressed -> btn_n[3] low 2 cycles later; released -> high 2 cycles later.
REQ-032 joy p1 bit8 held 100 cycles, COIN_LEN=16 -> player-1 coin low exactly 16 cycles, once; second press at cycle 5 of pulse ignored.
REQ-033 joy bit9 pulses on both players same cycle -> pause 0->1 once; next pulse -> 0; reset -> 0.
REQ-034 af_en=1, AF_HALF=4, fire held 20 cycles -> fire output low 4, high 4 repeating, starting low; release -> high next cycle.
REQ-035 MERGE=0, NPLAYERS=2: joy player1 bit0 -> only player 1 right active; keyboard 74 -> only player 0 right.
REQ-036 Coin held through reset deassertion -> no coin pulse; ps2 toggle unchanged across reset -> no key event.
